cmos_frame_packer: RTL and testbench

Capture-side stage directly upstream of the DDR frame-buffer FIFO controller. It samples the OV5640 8-bit DVP stream, assembles RGB565 pixels, and packs two pixels per 32-bit word for the DDR write FIFO. It also generates the write enable, the frame-active flag and the per-frame bank-switch pulse. Capture is held off until DDR init and camera register config are both done, and the first settling frames are discarded.

---
 rtl/cmos_frame_packer.sv | 150 +++++++++++++++
 tb/tb_cmos_frame_packer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_frame_packer.sv
// OV5640 DVP capture: waits for init, drops settling frames, then packs RGB565
// byte pairs two pixels per 32-bit word for the DDR write FIFO.
module cmos_frame_packer #(
    parameter int H_PIXELS   = 480,
    parameter int V_LINES    = 272,
    parameter int FRAME_SKIP = 10,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_done,
    input  logic             camera_vsync,
    input  logic             camera_href,
    input  logic [7:0]       camera_data,
    output logic             ddr_wren,
    output logic [31:0]      ddr_data,
    output logic             data_valid_wr,
    output logic             frame_switch,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt
);
    localparam int BW  = $clog2(2*H_PIXELS+1) + 1;
    localparam int LW  = $clog2(V_LINES+1) + 1;
    localparam int SKW = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP+1) : 1;
    localparam logic [BW-1:0]  LINE_BYTES = BW'(2*H_PIXELS);
    localparam logic [LW-1:0]  LINES      = LW'(V_LINES);
    localparam logic [SKW-1:0] SKIP_LAST  = SKW'(FRAME_SKIP-1);

    typedef enum logic [2:0] {IDLE, WAIT_VS, SKIP, WAIT_VS2, ACTIVE} state_t;
    state_t state;

    logic           vsync_s1, vsync_s2, href_s1, href_s2;
    logic [7:0]     data_s1;
    logic [1:0]     phase;
    logic [31:0]    word;
    logic           word_rdy;
    logic [BW-1:0]  byte_cnt;
    logic [LW-1:0]  line_cnt;
    logic [SKW-1:0] skip_cnt;

    logic vs_rise, vs_fall, href_rise, href_fall;
    logic [1:0] ph_cur;

    assign vs_rise   =  vsync_s1 & ~vsync_s2;
    assign vs_fall   = ~vsync_s1 &  vsync_s2;
    assign href_rise =  href_s1  & ~href_s2;
    assign href_fall = ~href_s1  &  href_s2;
    assign ph_cur    = href_rise ? 2'd0 : phase;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            vsync_s1      <= 1'b0;
            vsync_s2      <= 1'b0;
            href_s1       <= 1'b0;
            href_s2       <= 1'b0;
            data_s1       <= '0;
            phase         <= '0;
            word          <= '0;
            word_rdy      <= 1'b0;
            byte_cnt      <= '0;
            line_cnt      <= '0;
            skip_cnt      <= '0;
            ddr_wren      <= 1'b0;
            ddr_data      <= '0;
            data_valid_wr <= 1'b0;
            frame_switch  <= 1'b0;
            frame_err     <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            vsync_s1     <= camera_vsync;
            href_s1      <= camera_href;
            data_s1      <= camera_data;
            vsync_s2     <= vsync_s1;
            href_s2      <= href_s1;
            frame_switch <= 1'b0;
            word_rdy     <= 1'b0;
            // a word still in flight when init drops is discarded with the frame
            ddr_wren     <= word_rdy & init_done;
            if (word_rdy && init_done)
                ddr_data <= word;

            if (!init_done) begin
                state         <= IDLE;
                data_valid_wr <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= WAIT_VS;
                        skip_cnt <= '0;
                    end
                    WAIT_VS, WAIT_VS2: begin
                        if (vs_fall) begin
                            if (state == WAIT_VS && FRAME_SKIP > 0) begin
                                state <= SKIP;
                            end else begin
                                state         <= ACTIVE;
                                data_valid_wr <= 1'b1;
                                byte_cnt      <= '0;
                                line_cnt      <= '0;
                                frame_err     <= 1'b0;
                            end
                        end
                    end
                    SKIP: begin
                        if (vs_rise) begin
                            skip_cnt <= skip_cnt + 1'b1;
                            if (skip_cnt == SKIP_LAST)
                                state <= WAIT_VS2;
                        end
                    end
                    ACTIVE: begin
                        if (vs_rise) begin
                            // a byte arriving with the vsync edge is dropped and flagged
                            state         <= WAIT_VS2;
                            data_valid_wr <= 1'b0;
                            frame_switch  <= 1'b1;
                            frame_cnt     <= frame_cnt + 1'b1;
                            if (line_cnt != LINES || href_s1)
                                frame_err <= 1'b1;
                        end else begin
                            if (href_s1) begin
                                case (ph_cur)
                                    2'd0: word[31:24] <= data_s1;
                                    2'd1: word[23:16] <= data_s1;
                                    2'd2: word[15:8]  <= data_s1;
                                    default: begin
                                        word[7:0] <= data_s1;
                                        word_rdy  <= 1'b1;
                                    end
                                endcase
                                phase    <= ph_cur + 2'd1;
                                byte_cnt <= byte_cnt + 1'b1;
                                if (byte_cnt >= LINE_BYTES)
                                    frame_err <= 1'b1;
                            end
                            if (href_fall) begin
                                line_cnt <= line_cnt + 1'b1;
                                byte_cnt <= '0;
                                if (byte_cnt != LINE_BYTES)
                                    frame_err <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cmos_frame_packer.sv
// Randomized DVP frames against a byte-list model of the expected packed words.
module tb_cmos_frame_packer;
    localparam int H   = 8;
    localparam int V   = 4;
    localparam int SK  = 2;
    localparam int CW  = 8;
    localparam int LB  = 2*H;
    localparam int WPF = H*V/2;

    logic          clk = 0, rst_n = 0, init_done = 0;
    logic          camera_vsync = 0, camera_href = 0;
    logic [7:0]    camera_data = 0;
    logic          ddr_wren, data_valid_wr, frame_switch, frame_err;
    logic [31:0]   ddr_data;
    logic [CW-1:0] frame_cnt;

    cmos_frame_packer #(.H_PIXELS(H), .V_LINES(V), .FRAME_SKIP(SK), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .camera_vsync(camera_vsync), .camera_href(camera_href), .camera_data(camera_data),
        .ddr_wren(ddr_wren), .ddr_data(ddr_data), .data_valid_wr(data_valid_wr),
        .frame_switch(frame_switch), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] got_q[$], exp_q[$];
    logic [7:0]  pat [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    int wren_cnt, sw_cnt, first_wren_cyc = -1, d4_edge, exp_fc;
    bit dvw_seen;
    int n_chk = 0, n_pass = 0;

    always @(negedge clk) begin
        if (ddr_wren === 1'b1) begin
            got_q.push_back(ddr_data);
            wren_cnt++;
            if (first_wren_cyc < 0) first_wren_cyc = cyc;
        end
        if (frame_switch === 1'b1) sw_cnt++;
        if (data_valid_wr === 1'b1) dvw_seen = 1;
    end

    task automatic clear_mon();
        @(posedge clk);
        got_q.delete(); exp_q.delete();
        wren_cnt = 0; sw_cnt = 0; first_wren_cyc = -1; dvw_seen = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vs_high();
        @(negedge clk); camera_vsync = 1; camera_href = 0;
        idle(2);
    endtask

    task automatic vs_low();
        @(negedge clk); camera_vsync = 0;
        idle(2);
    endtask

    task automatic drive_line(input int nb, input bit cap, input bit fixed4);
        logic [7:0] b[$];
        logic [7:0] v;
        for (int i = 0; i < nb; i++) begin
            v = 8'($urandom);
            if (fixed4 && i < 4) v = pat[i];
            b.push_back(v);
            @(negedge clk); camera_href = 1; camera_data = v;
            if (fixed4 && i == 3) d4_edge = cyc + 1;
        end
        @(negedge clk); camera_href = 0;
        idle(2);
        if (cap)
            for (int w = 0; w < nb/4; w++)
                exp_q.push_back({b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]});
    endtask

    task automatic drive_frame(input bit cap, input int short_ln, input bit fixed4);
        vs_high(); vs_low();
        for (int l = 0; l < V; l++)
            drive_line((l == short_ln) ? LB-2 : LB, cap, fixed4 && l == 0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if ({ddr_wren, data_valid_wr, frame_switch, frame_err} !== 4'b0)
            $display("FAIL reset_flags: got %b want 0000", {ddr_wren, data_valid_wr, frame_switch, frame_err});
        else n_pass++;
        n_chk++; if (ddr_data !== 32'h0) $display("FAIL reset_data: got %h want 0", ddr_data); else n_pass++;
        n_chk++; if (frame_cnt !== '0) $display("FAIL reset_cnt: got %0d want 0", frame_cnt); else n_pass++;
        rst_n = 1;
        clear_mon();
        drive_frame(0, -1, 0); drive_frame(0, -1, 0); vs_high(); idle(2);
        n_chk++; if (wren_cnt !== 0) $display("FAIL idle_wren: got %0d want 0", wren_cnt); else n_pass++;
        n_chk++; if (dvw_seen !== 0) $display("FAIL idle_dvw: got %0d want 0", dvw_seen); else n_pass++;
        n_chk++; if (frame_cnt !== '0) $display("FAIL idle_cnt: got %0d want 0", frame_cnt); else n_pass++;
    endtask

    task automatic test_skip_start();
        @(negedge clk); init_done = 1;
        clear_mon();
        drive_frame(0, -1, 0);
        n_chk++; if (data_valid_wr !== 0) $display("FAIL skip_dvw: got %0d want 0", data_valid_wr); else n_pass++;
        drive_frame(0, -1, 0);
        n_chk++; if (wren_cnt !== 0) $display("FAIL skip_wren: got %0d want 0", wren_cnt); else n_pass++;
        drive_frame(1, -1, 0); drive_frame(1, -1, 0); vs_high(); idle(2);
        exp_fc += 2;
        n_chk++; if (got_q.size() !== 2*WPF) $display("FAIL start_words: got %0d want %0d", got_q.size(), 2*WPF); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (got_q[i] !== exp_q[i]) $display("FAIL start_word%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_chk++; if (sw_cnt !== 2) $display("FAIL start_switch: got %0d want 2", sw_cnt); else n_pass++;
        n_chk++; if (frame_cnt !== CW'(exp_fc)) $display("FAIL start_cnt: got %0d want %0d", frame_cnt, exp_fc); else n_pass++;
        n_chk++; if (frame_err !== 0) $display("FAIL start_err: got %0d want 0", frame_err); else n_pass++;
    endtask

    task automatic test_packing();
        clear_mon();
        drive_frame(1, -1, 1); vs_high(); idle(2);
        exp_fc++;
        n_chk++; if (got_q.size() == 0 || got_q[0] !== 32'hA1B2C3D4)
            $display("FAIL pack_order: got %h want a1b2c3d4", (got_q.size() > 0) ? got_q[0] : 32'hx);
        else n_pass++;
        n_chk++; if (first_wren_cyc - d4_edge !== 2)
            $display("FAIL pack_latency: got %0d want 2", first_wren_cyc - d4_edge);
        else n_pass++;
        n_chk++; if (got_q.size() !== WPF) $display("FAIL pack_words: got %0d want %0d", got_q.size(), WPF); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (got_q[i] !== exp_q[i]) $display("FAIL pack_word%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_short_line();
        clear_mon();
        drive_frame(1, 1, 0);
        n_chk++; if (frame_err !== 1) $display("FAIL short_err: got %0d want 1", frame_err); else n_pass++;
        vs_high(); idle(2);
        exp_fc++;
        n_chk++; if (frame_err !== 1) $display("FAIL short_err_hold: got %0d want 1", frame_err); else n_pass++;
        n_chk++; if (got_q.size() !== WPF-1) $display("FAIL short_words: got %0d want %0d", got_q.size(), WPF-1); else n_pass++;
        drive_frame(1, -1, 0); vs_high(); idle(2);
        exp_fc++;
        n_chk++; if (frame_err !== 0) $display("FAIL short_err_clear: got %0d want 0", frame_err); else n_pass++;
        n_chk++; if (got_q.size() !== 2*WPF-1) $display("FAIL short_total: got %0d want %0d", got_q.size(), 2*WPF-1); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (got_q[i] !== exp_q[i]) $display("FAIL short_word%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_chk++; if (sw_cnt !== 2) $display("FAIL short_switch: got %0d want 2", sw_cnt); else n_pass++;
    endtask

    task automatic test_abort();
        localparam int K = 3;
        logic [7:0] b[$];
        logic [7:0] v;
        clear_mon();
        vs_high(); vs_low();
        for (int j = 0; j < LB; j++) begin
            v = 8'($urandom);
            b.push_back(v);
            @(negedge clk);
            if (j == 4*K+3) begin
                n_chk++; if (data_valid_wr !== 0) $display("FAIL abort_dvw: got %0d want 0", data_valid_wr); else n_pass++;
            end
            camera_href = 1; camera_data = v;
            if (j == 4*K+2) init_done = 0;
        end
        @(negedge clk); camera_href = 0;
        idle(2);
        for (int w = 0; w < K; w++) exp_q.push_back({b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]});
        for (int l = 1; l < V; l++) drive_line(LB, 0, 0);
        vs_high(); idle(2);
        n_chk++; if (wren_cnt !== K) $display("FAIL abort_wren: got %0d want %0d", wren_cnt, K); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (got_q[i] !== exp_q[i]) $display("FAIL abort_word%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_chk++; if (sw_cnt !== 0) $display("FAIL abort_switch: got %0d want 0", sw_cnt); else n_pass++;
        n_chk++; if (frame_cnt !== CW'(exp_fc)) $display("FAIL abort_cnt: got %0d want %0d", frame_cnt, exp_fc); else n_pass++;
    endtask

    task automatic test_mid_reset();
        @(negedge clk); init_done = 1;
        drive_frame(0, -1, 0); drive_frame(0, -1, 0);
        vs_high(); vs_low();
        for (int j = 0; j < 10; j++) begin
            @(negedge clk); camera_href = 1; camera_data = 8'($urandom);
        end
        n_chk++; if (data_valid_wr !== 1) $display("FAIL mrst_active: got %0d want 1", data_valid_wr); else n_pass++;
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        n_chk++; if ({ddr_wren, data_valid_wr, frame_switch, frame_err} !== 4'b0)
            $display("FAIL mrst_flags: got %b want 0000", {ddr_wren, data_valid_wr, frame_switch, frame_err});
        else n_pass++;
        n_chk++; if (ddr_data !== 32'h0 || frame_cnt !== '0)
            $display("FAIL mrst_data_cnt: got %h/%0d want 0/0", ddr_data, frame_cnt);
        else n_pass++;
        camera_href = 0;
        idle(2);
        exp_fc = 0;
        clear_mon();
        drive_frame(0, -1, 0); drive_frame(0, -1, 0); drive_frame(1, -1, 0); vs_high(); idle(2);
        exp_fc++;
        n_chk++; if (got_q.size() !== WPF) $display("FAIL mrst_words: got %0d want %0d", got_q.size(), WPF); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_chk++; if (got_q[i] !== exp_q[i]) $display("FAIL mrst_word%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_chk++; if (sw_cnt !== 1) $display("FAIL mrst_switch: got %0d want 1", sw_cnt); else n_pass++;
        n_chk++; if (frame_cnt !== CW'(exp_fc)) $display("FAIL mrst_cnt: got %0d want %0d", frame_cnt, exp_fc); else n_pass++;
    endtask

    initial begin
        exp_fc = 0;
        test_reset();
        test_skip_start();
        test_packing();
        test_short_line();
        test_abort();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
